apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
- Upstream APB requester that feeds the team's APB SRAM slave: converts a simple valid/ready command stream into compliant APB4 SETUP/ACCESS transfers.
- Waits on PREADY, then returns read data and error status on a valid/ready response channel.
- Sits between the on-chip command source (test controller / CPU-side logic) and the APB slave bus.
- Includes a wait-state timeout that guards against a hung slave.

Parameters:
- ADDR_WIDTH, 32, width of cmd_addr and PADDR
- DATA_WIDTH, 32, width of write/read data; strobe width is DATA_WIDTH/8
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles without PREADY before abort; 0 disables the timeout

Ports:
- PCLK  in  1  clock
- PRESETn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_WIDTH  transfer address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_strb  in  DATA_WIDTH/8  write byte strobes
- cmd_prot  in  3  protection attributes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes and timeouts)
- rsp_err  out  1  PSLVERR or timeout
- rsp_timeout  out  1  response was a timeout abort
- PSEL, PENABLE, PWRITE  out  1 each  APB control
- PADDR  out  ADDR_WIDTH  APB address
- PWDATA  out  DATA_WIDTH  APB write data
- PSTRB  out  DATA_WIDTH/8  APB strobes
- PPROT  out  3  APB protection
- PRDATA  in  DATA_WIDTH  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB slave error

Behaviour:
- One clock, PCLK. Reset is asynchronous and active-low (PRESETn). All outputs are registered.
- Reset values:
  - All outputs 0, except cmd_ready=1.
  - State is IDLE and the wait counter is 0.
  - Assertion of PRESETn mid-transfer aborts immediately: PSEL/PENABLE drop, and any pending response is discarded.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1, PSEL=0, PENABLE=0.
  - On cmd_valid: capture command into PADDR/PWRITE/PWDATA/PSTRB/PPROT, set cmd_ready=0, go to SETUP.
  - For reads, PSTRB is driven 0 and PWDATA holds its previous value.
- SETUP: exactly one cycle with PSEL=1, PENABLE=0; then go to ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1. All APB address/control/data outputs are stable from SETUP through the end of ACCESS.
  - On PREADY=1:
    - rsp_rdata = PRDATA for reads, 0 for writes.
    - rsp_err = PSLVERR; rsp_timeout = 0.
    - Drop PSEL/PENABLE and go to RESP.
  - On PREADY=0: increment the wait counter.
  - Timeout: if TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES with PREADY still 0:
    - Drop PSEL/PENABLE.
    - rsp_err=1, rsp_timeout=1, rsp_rdata=0.
    - Go to RESP.
    - This is a deliberate protocol abort for slave hang recovery.
  - If PREADY rises in the same cycle the counter hits the limit, PREADY wins and it is a normal completion.
  - The wait counter clears on entry to SETUP. Its width is clog2(TIMEOUT_CYCLES+1).
- RESP:
  - rsp_valid=1, and rsp_* are held stable until rsp_ready.
  - On rsp_ready: rsp_valid=0, cmd_ready=1, go to IDLE.
  - A new command is not accepted in RESP.
- Timing:
  - Minimum command-accept to rsp_valid is 3 cycles (zero-wait slave).
  - Minimum command-to-command throughput is 4 cycles.
  - PADDR/PWDATA/PPROT hold their last values while idle; APB outputs never glitch between transfers.
- No buffering: only one outstanding transfer. cmd_* is sampled only in the IDLE handshake cycle.

Test Plan:
- Write, zero-wait slave: cmd addr=0x10, wdata=0xA5, strb=4'hF -> one SETUP cycle, then ACCESS with PSEL=1/PENABLE=1/PWRITE=1/PADDR=0x10; rsp_valid 3 cycles after accept; rsp_err=0, rsp_rdata=0.
- Read with 2 wait states: PREADY low for 2 ACCESS cycles, then high with PRDATA=0x000000A5 -> PADDR stable for all 3 ACCESS cycles; PSTRB=0; rsp_rdata=0xA5, rsp_err=0.
- Slave error: PREADY=1, PSLVERR=1 on a read -> rsp_err=1, rsp_timeout=0, rsp_rdata=PRDATA.
- Timeout with TIMEOUT_CYCLES=4 and PREADY stuck 0 -> exactly 4 ACCESS cycles, then PSEL=0; rsp_err=1, rsp_timeout=1, rsp_rdata=0. PREADY arriving on the 4th cycle -> normal completion instead.
- Response backpressure and back-to-back: hold rsp_ready=0 for 5 cycles -> rsp_* stable and cmd_ready=0 throughout, with cmd_valid held high; a second command is accepted only after rsp_ready, and its SETUP appears 2 cycles after the response handshake.
- Reset mid-ACCESS: deassert PRESETn asynchronously between clock edges -> PSEL/PENABLE/rsp_valid go 0 immediately; after release, state is IDLE with cmd_ready=1 and a fresh transfer completes normally.

Source files
------------

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - APB4 requester turning a valid/ready command stream into APB transfers
//
// Ports:
//   PCLK, PRESETn                       clock, asynchronous active-low reset
//   cmd_valid/cmd_ready, cmd_write,     command channel (sampled only in the IDLE handshake)
//   cmd_addr, cmd_wdata, cmd_strb, cmd_prot
//   rsp_valid/rsp_ready, rsp_rdata,     response channel (held stable until consumed)
//   rsp_err, rsp_timeout
//   PSEL, PENABLE, PWRITE, PADDR,       APB4 requester outputs (all registered)
//   PWDATA, PSTRB, PPROT
//   PRDATA, PREADY, PSLVERR             APB4 completer inputs

module apb_master_bridge #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                    PCLK,
   input  logic                    PRESETn,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0] cmd_strb,
   input  logic [2:0]              cmd_prot,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    rsp_err,
   output logic                    rsp_timeout,
   output logic                    PSEL,
   output logic                    PENABLE,
   output logic                    PWRITE,
   output logic [ADDR_WIDTH-1:0]   PADDR,
   output logic [DATA_WIDTH-1:0]   PWDATA,
   output logic [DATA_WIDTH/8-1:0] PSTRB,
   output logic [2:0]              PPROT,
   input  logic [DATA_WIDTH-1:0]   PRDATA,
   input  logic                    PREADY,
   input  logic                    PSLVERR
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   // A zero limit disables the timeout; keep the counter at least one bit wide.
   localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);
   localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [CNT_WIDTH-1:0]    wait_cnt_q, wait_cnt_d;
   logic [CNT_WIDTH-1:0]    wait_cnt_inc;
   logic                    cmd_ready_q, cmd_ready_d;
   logic                    psel_q, psel_d;
   logic                    penable_q, penable_d;
   logic                    pwrite_q, pwrite_d;
   logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
   logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
   logic [STRB_WIDTH-1:0]   pstrb_q, pstrb_d;
   logic [2:0]              pprot_q, pprot_d;
   logic                    rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                    rsp_err_q, rsp_err_d;
   logic                    rsp_timeout_q, rsp_timeout_d;

   assign wait_cnt_inc = wait_cnt_q + CNT_WIDTH'(1);

   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      cmd_ready_d   = cmd_ready_q;
      psel_d        = psel_q;
      penable_d     = penable_q;
      pwrite_d      = pwrite_q;
      paddr_d       = paddr_q;
      pwdata_d      = pwdata_q;
      pstrb_d       = pstrb_q;
      pprot_d       = pprot_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_err_d     = rsp_err_q;
      rsp_timeout_d = rsp_timeout_q;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               pwrite_d    = cmd_write;
               paddr_d     = cmd_addr;
               pprot_d     = cmd_prot;
               // Reads leave PWDATA untouched so the bus does not toggle needlessly.
               pwdata_d    = cmd_write ? cmd_wdata : pwdata_q;
               pstrb_d     = cmd_write ? cmd_strb : '0;
               psel_d      = 1'b1;
               cmd_ready_d = 1'b0;
               wait_cnt_d  = '0;
               state_d     = S_SETUP;
            end
         end

         S_SETUP: begin
            penable_d = 1'b1;
            state_d   = S_ACCESS;
         end

         S_ACCESS: begin
            // PREADY is checked first so a completion on the limit cycle is normal.
            if (PREADY) begin
               rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
               rsp_err_d     = PSLVERR;
               rsp_timeout_d = 1'b0;
               rsp_valid_d   = 1'b1;
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               state_d       = S_RESP;
            end else if (TIMEOUT_EN && (wait_cnt_inc == CNT_LIMIT)) begin
               // Deliberate protocol abort to recover from a hung completer.
               rsp_rdata_d   = '0;
               rsp_err_d     = 1'b1;
               rsp_timeout_d = 1'b1;
               rsp_valid_d   = 1'b1;
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               state_d       = S_RESP;
            end else begin
               wait_cnt_d = wait_cnt_inc;
            end
         end

         S_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
               state_d     = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q       <= S_IDLE;
         wait_cnt_q    <= '0;
         cmd_ready_q   <= 1'b1;
         psel_q        <= 1'b0;
         penable_q     <= 1'b0;
         pwrite_q      <= 1'b0;
         paddr_q       <= '0;
         pwdata_q      <= '0;
         pstrb_q       <= '0;
         pprot_q       <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         cmd_ready_q   <= cmd_ready_d;
         psel_q        <= psel_d;
         penable_q     <= penable_d;
         pwrite_q      <= pwrite_d;
         paddr_q       <= paddr_d;
         pwdata_q      <= pwdata_d;
         pstrb_q       <= pstrb_d;
         pprot_q       <= pprot_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end

   assign cmd_ready   = cmd_ready_q;
   assign PSEL        = psel_q;
   assign PENABLE     = penable_q;
   assign PWRITE      = pwrite_q;
   assign PADDR       = paddr_q;
   assign PWDATA      = pwdata_q;
   assign PSTRB       = pstrb_q;
   assign PPROT       = pprot_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - directed scoreboard bench for apb_master_bridge

module tb_apb_master_bridge;

   logic        PCLK = 1'b0;
   logic        PRESETn;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_strb;
   logic [2:0]  cmd_prot;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        rsp_timeout;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PADDR;
   logic [31:0] PWDATA;
   logic [3:0]  PSTRB;
   logic [2:0]  PPROT;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic        to;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   apb_master_bridge #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32),
      .TIMEOUT_CYCLES(4)
   ) dut (
      .PCLK(PCLK),
      .PRESETn(PRESETn),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_write(cmd_write),
      .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata),
      .cmd_strb(cmd_strb),
      .cmd_prot(cmd_prot),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err),
      .rsp_timeout(rsp_timeout),
      .PSEL(PSEL),
      .PENABLE(PENABLE),
      .PWRITE(PWRITE),
      .PADDR(PADDR),
      .PWDATA(PWDATA),
      .PSTRB(PSTRB),
      .PPROT(PPROT),
      .PRDATA(PRDATA),
      .PREADY(PREADY),
      .PSLVERR(PSLVERR)
   );

   always #5 PCLK = ~PCLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge PCLK);
   endtask

   task automatic push_exp(input logic [31:0] rdata, input logic err, input logic to);
      exp_t e;
      e.rdata = rdata;
      e.err   = err;
      e.to    = to;
      sb.push_back(e);
   endtask

   // Present one command in IDLE, check it is accepted, leave the bench in the SETUP cycle.
   task automatic issue(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_wdata = wdata;
      cmd_strb  = strb;
      cmd_prot  = prot;
      chk({tag, "_accept"}, 64'(cmd_ready), 64'd1);
      cyc();
      cmd_valid = 1'b0;
   endtask

   // Consume one response (bounded wait) and compare it against the scoreboard head.
   task automatic collect(input string tag);
      int   n;
      exp_t e;
      n = 0;
      rsp_ready = 1'b1;
      while (rsp_valid !== 1'b1 && n < 50) begin
         cyc();
         n++;
      end
      chk({tag, "_rsp_seen"}, 64'(rsp_valid), 64'd1);
      chk({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
      if (rsp_valid === 1'b1 && sb.size() != 0) begin
         e = sb.pop_front();
         chk({tag, "_rdata"}, 64'(rsp_rdata), 64'(e.rdata));
         chk({tag, "_err"}, 64'(rsp_err), 64'(e.err));
         chk({tag, "_timeout"}, 64'(rsp_timeout), 64'(e.to));
      end
      cyc();
      rsp_ready = 1'b0;
   endtask

   initial begin
      int n;
      PRESETn   = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      cmd_strb  = '0;
      cmd_prot  = '0;
      rsp_ready = 1'b0;
      PRDATA    = '0;
      PREADY    = 1'b0;
      PSLVERR   = 1'b0;
      cyc();
      cyc();

      // Reset values
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("rst_psel", 64'(PSEL), 64'd0);
      chk("rst_penable", 64'(PENABLE), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_paddr", 64'(PADDR), 64'd0);
      chk("rst_rsp_err", 64'(rsp_err), 64'd0);
      PRESETn = 1'b1;
      cyc();

      // Write, zero-wait slave
      PREADY = 1'b1;
      PRDATA = 32'hDEAD_BEEF;
      push_exp(32'h0, 1'b0, 1'b0);
      issue("wr0", 1'b1, 32'h10, 32'hA5, 4'hF, 3'h2);
      chk("wr0_setup_psel", 64'(PSEL), 64'd1);
      chk("wr0_setup_penable", 64'(PENABLE), 64'd0);
      chk("wr0_setup_pwrite", 64'(PWRITE), 64'd1);
      chk("wr0_setup_paddr", 64'(PADDR), 64'h10);
      chk("wr0_setup_pwdata", 64'(PWDATA), 64'hA5);
      chk("wr0_setup_pstrb", 64'(PSTRB), 64'hF);
      chk("wr0_setup_pprot", 64'(PPROT), 64'h2);
      cyc();
      chk("wr0_access_psel", 64'(PSEL), 64'd1);
      chk("wr0_access_penable", 64'(PENABLE), 64'd1);
      chk("wr0_access_paddr", 64'(PADDR), 64'h10);
      chk("wr0_access_no_rsp", 64'(rsp_valid), 64'd0);
      cyc();
      chk("wr0_rsp_at_3", 64'(rsp_valid), 64'd1);
      chk("wr0_psel_dropped", 64'(PSEL), 64'd0);
      collect("wr0");

      // Read with two wait states
      PREADY = 1'b0;
      PRDATA = 32'h0;
      push_exp(32'hA5, 1'b0, 1'b0);
      issue("rd2", 1'b0, 32'h20, 32'h1234, 4'hF, 3'h0);
      chk("rd2_pstrb", 64'(PSTRB), 64'h0);
      chk("rd2_pwdata_held", 64'(PWDATA), 64'hA5);
      cyc();
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rd2_access%0d_en", i), 64'(PSEL & PENABLE), 64'd1);
         chk($sformatf("rd2_access%0d_paddr", i), 64'(PADDR), 64'h20);
         if (i == 2) begin
            PREADY = 1'b1;
            PRDATA = 32'h0000_00A5;
         end
         cyc();
      end
      chk("rd2_rsp_valid", 64'(rsp_valid), 64'd1);
      collect("rd2");

      // Slave error on a read
      PREADY  = 1'b1;
      PSLVERR = 1'b1;
      PRDATA  = 32'h5A5A_0001;
      push_exp(32'h5A5A_0001, 1'b1, 1'b0);
      issue("err", 1'b0, 32'h24, 32'h0, 4'h0, 3'h1);
      collect("err");
      PSLVERR = 1'b0;

      // Timeout with PREADY stuck low
      PREADY = 1'b0;
      PRDATA = 32'hFFFF_FFFF;
      push_exp(32'h0, 1'b1, 1'b1);
      issue("to", 1'b0, 32'h28, 32'h0, 4'h0, 3'h0);
      cyc();
      n = 0;
      while (PSEL === 1'b1 && PENABLE === 1'b1 && n < 20) begin
         n++;
         cyc();
      end
      chk("to_access_cycles", 64'(n), 64'd4);
      chk("to_psel_dropped", 64'(PSEL), 64'd0);
      collect("to");

      // PREADY on the limit cycle wins
      PREADY = 1'b0;
      push_exp(32'h77, 1'b0, 1'b0);
      issue("lim", 1'b0, 32'h2C, 32'h0, 4'h0, 3'h0);
      cyc();
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("lim_access%0d_en", i), 64'(PSEL & PENABLE), 64'd1);
         if (i == 3) begin
            PREADY = 1'b1;
            PRDATA = 32'h77;
         end
         cyc();
      end
      collect("lim");

      // Response backpressure, then a back-to-back command held on cmd_valid
      PREADY = 1'b1;
      PRDATA = 32'h0;
      push_exp(32'h0, 1'b0, 1'b0);
      issue("bp1", 1'b1, 32'h30, 32'hCAFE, 4'h3, 3'h0);
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 32'h40;
      cmd_wdata = 32'h0;
      cmd_strb  = 4'h0;
      cyc();
      cyc();
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bp_hold%0d_valid", i), 64'(rsp_valid), 64'd1);
         chk($sformatf("bp_hold%0d_rdata", i), 64'(rsp_rdata), 64'h0);
         chk($sformatf("bp_hold%0d_err", i), 64'(rsp_err), 64'd0);
         chk($sformatf("bp_hold%0d_cmd_ready", i), 64'(cmd_ready), 64'd0);
         chk($sformatf("bp_hold%0d_psel", i), 64'(PSEL), 64'd0);
         cyc();
      end
      PRDATA = 32'h99;
      collect("bp1");
      push_exp(32'h99, 1'b0, 1'b0);
      chk("bp2_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("bp2_idle_psel", 64'(PSEL), 64'd0);
      cyc();
      cmd_valid = 1'b0;
      chk("bp2_setup_psel", 64'(PSEL), 64'd1);
      chk("bp2_setup_penable", 64'(PENABLE), 64'd0);
      chk("bp2_setup_paddr", 64'(PADDR), 64'h40);
      chk("bp2_setup_pwrite", 64'(PWRITE), 64'd0);
      collect("bp2");

      // Asynchronous reset in the middle of ACCESS
      PREADY = 1'b0;
      issue("rst", 1'b0, 32'h50, 32'h0, 4'h0, 3'h0);
      cyc();
      chk("rst_mid_access", 64'(PSEL & PENABLE), 64'd1);
      #2;
      PRESETn = 1'b0;
      #1;
      chk("rst_async_psel", 64'(PSEL), 64'd0);
      chk("rst_async_penable", 64'(PENABLE), 64'd0);
      chk("rst_async_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_async_cmd_ready", 64'(cmd_ready), 64'd1);
      cyc();
      cyc();
      PRESETn = 1'b1;
      cyc();
      chk("rst_after_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("rst_after_psel", 64'(PSEL), 64'd0);
      PREADY = 1'b1;
      push_exp(32'h0, 1'b0, 1'b0);
      issue("post", 1'b1, 32'h54, 32'h11, 4'hF, 3'h0);
      collect("post");

      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
